// File: rtl/pci_target_ctrl.sv
// PCI target responder: BAR hits become single-beat AXI4 writes or delayed AXI reads.
// Optional macro PCI_TGT_DISCARD_EN drops an unclaimed delayed read after DISCARD_CYCLES.
//
// state       | meaning
// ST_IDLE     | no transaction, no delayed read pending
// ST_WR_WAIT  | write accepted, waiting for a data phase (S_READY=1)
// ST_WR_AXI   | AW/W channels presented, each drops on its own ready
// ST_WR_RESP  | waiting for B response
// ST_RD_ISSUE | delayed read: AR presented
// ST_RD_WAIT  | delayed read: waiting for R beat
// ST_RD_HOLD  | read data held, waiting for the master to retry the same address
// ST_RD_RET   | returning held datum with disconnect
// ST_RD_ABT   | target abort for a failed read
module pci_target_ctrl #(
  parameter int unsigned BAR_NUM        = 0,
  parameter int unsigned BAR_SIZE_LOG2  = 12,
  parameter logic [31:0] AXI_BASE       = 32'h0000_0000,
  parameter logic [15:0] DISCARD_CYCLES = 16'd32768
) (
  input  logic        tgt_m_aclk,
  input  logic        tgt_m_aresetn,
  input  logic [31:0] ADDR,
  input  logic        ADDR_VLD,
  input  logic [7:0]  BASE_HIT,
  input  logic        S_WRDN,
  input  logic        S_DATA,
  input  logic        S_DATA_VLD,
  input  logic        S_SRC_EN,
  input  logic [3:0]  S_CBE,
  input  logic [31:0] ADIO_OUT,
  output logic [31:0] ADIO_IN,
  output logic        S_READY,
  output logic        S_TERM,
  output logic        S_ABORT,
  output logic [31:0] tgt_m_awaddr,
  output logic        tgt_m_awvalid,
  input  logic        tgt_m_awready,
  output logic [31:0] tgt_m_wdata,
  output logic [3:0]  tgt_m_wstrb,
  output logic        tgt_m_wvalid,
  input  logic        tgt_m_wready,
  input  logic [1:0]  tgt_m_bresp,
  input  logic        tgt_m_bvalid,
  output logic        tgt_m_bready,
  output logic [31:0] tgt_m_araddr,
  output logic        tgt_m_arvalid,
  input  logic        tgt_m_arready,
  input  logic [31:0] tgt_m_rdata,
  input  logic [1:0]  tgt_m_rresp,
  input  logic        tgt_m_rvalid,
  output logic        tgt_m_rready,
  output logic        wr_err
);

  localparam int unsigned OFS_W   = BAR_SIZE_LOG2 - 2;
  localparam logic [2:0]  BAR_IDX = 3'(BAR_NUM);

  typedef enum logic [3:0] {
    ST_IDLE, ST_WR_WAIT, ST_WR_AXI, ST_WR_RESP,
    ST_RD_ISSUE, ST_RD_WAIT, ST_RD_HOLD, ST_RD_RET, ST_RD_ABT
  } state_t;

  state_t            r_state;
  logic [OFS_W-1:0]  r_wr_ofs;
  logic [29:0]       r_rd_pci;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [31:0]       r_adio;
  logic              r_s_ready;
  logic              r_s_term;
  logic              r_s_abort;
  logic              r_retry;
  logic [31:0]       r_awaddr;
  logic              r_awvalid;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_wvalid;
  logic              r_bready;
  logic [31:0]       r_araddr;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_wr_err;
`ifdef PCI_TGT_DISCARD_EN
  logic [15:0]       r_disc_cnt;
`endif

  logic w_hit;
  logic w_rd_match;
  logic w_retry_hit;
  logic w_retry_nxt;
  logic w_unused;

  assign w_hit      = ADDR_VLD & BASE_HIT[BAR_IDX];
  assign w_rd_match = w_hit & ~S_WRDN & (ADDR[31:2] == r_rd_pci);

  // Retry is independent of the FSM so a delayed read in flight can still turn away other masters.
  assign w_retry_hit = w_hit & (((r_state == ST_IDLE) & ~S_WRDN) |
                                (r_state == ST_RD_ISSUE) | (r_state == ST_RD_WAIT) |
                                ((r_state == ST_RD_HOLD) & ~w_rd_match));
  assign w_retry_nxt = w_retry_hit | (r_retry & S_DATA);

  assign w_unused = ^{S_SRC_EN, ADDR[1:0], BASE_HIT};

  always_ff @(posedge tgt_m_aclk or negedge tgt_m_aresetn) begin
    if (!tgt_m_aresetn) begin
      r_state    <= ST_IDLE;
      r_wr_ofs   <= '0;
      r_rd_pci   <= '0;
      r_rdata    <= '0;
      r_rresp    <= '0;
      r_adio     <= '0;
      r_s_ready  <= 1'b0;
      r_s_term   <= 1'b0;
      r_s_abort  <= 1'b0;
      r_retry    <= 1'b0;
      r_awaddr   <= '0;
      r_awvalid  <= 1'b0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_araddr   <= '0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_wr_err   <= 1'b0;
`ifdef PCI_TGT_DISCARD_EN
      r_disc_cnt <= '0;
`endif
    end else begin
      r_retry  <= w_retry_nxt;
      r_s_term <= w_retry_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_hit) begin
            if (S_WRDN) begin
              r_wr_ofs  <= ADDR[BAR_SIZE_LOG2-1:2];
              r_s_ready <= 1'b1;
              r_state   <= ST_WR_WAIT;
            end else begin
              r_rd_pci  <= ADDR[31:2];
              r_araddr  <= AXI_BASE | {{(32-BAR_SIZE_LOG2){1'b0}}, ADDR[BAR_SIZE_LOG2-1:2], 2'b00};
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ISSUE;
            end
          end
        end
        ST_WR_WAIT: begin
          if (S_DATA_VLD) begin
            r_awaddr  <= AXI_BASE | {{(32-BAR_SIZE_LOG2){1'b0}}, r_wr_ofs, 2'b00};
            r_wdata   <= ADIO_OUT;
            r_wstrb   <= ~S_CBE;
            r_s_ready <= 1'b0;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
            r_state   <= ST_WR_AXI;
          end else if (!S_DATA) begin
            r_s_ready <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_WR_AXI: begin
          if (tgt_m_awready) r_awvalid <= 1'b0;
          if (tgt_m_wready)  r_wvalid  <= 1'b0;
          if ((~r_awvalid | tgt_m_awready) & (~r_wvalid | tgt_m_wready)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (tgt_m_bvalid) begin
            r_bready <= 1'b0;
            if (tgt_m_bresp != 2'b00) r_wr_err <= 1'b1;
            r_wr_ofs <= r_wr_ofs + OFS_W'(1);
            if (S_DATA) begin
              r_s_ready <= 1'b1;
              r_state   <= ST_WR_WAIT;
            end else begin
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_RD_ISSUE: begin
          if (tgt_m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          if (tgt_m_rvalid) begin
            r_rready   <= 1'b0;
            r_rdata    <= tgt_m_rdata;
            r_rresp    <= tgt_m_rresp;
`ifdef PCI_TGT_DISCARD_EN
            r_disc_cnt <= DISCARD_CYCLES - 16'd1;
`endif
            r_state    <= ST_RD_HOLD;
          end
        end
        ST_RD_HOLD: begin
          if (w_rd_match) begin
            if (r_rresp == 2'b00) begin
              r_adio    <= r_rdata;
              r_s_ready <= 1'b1;
              r_s_term  <= 1'b1;
              r_state   <= ST_RD_RET;
            end else begin
              r_s_abort <= 1'b1;
              r_state   <= ST_RD_ABT;
            end
          end
`ifdef PCI_TGT_DISCARD_EN
          else if (r_disc_cnt == 16'd0) begin
            r_state <= ST_IDLE;
          end else begin
            r_disc_cnt <= r_disc_cnt - 16'd1;
          end
`endif
        end
        ST_RD_RET: begin
          if (S_DATA_VLD) begin
            r_adio    <= '0;
            r_s_ready <= 1'b0;
            r_state   <= ST_IDLE;
          end else begin
            r_s_term  <= 1'b1;
          end
        end
        ST_RD_ABT: begin
          if (!S_DATA) begin
            r_s_abort <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ADIO_IN       = r_adio;
  assign S_READY       = r_s_ready;
  assign S_TERM        = r_s_term;
  assign S_ABORT       = r_s_abort;
  assign tgt_m_awaddr  = r_awaddr;
  assign tgt_m_awvalid = r_awvalid;
  assign tgt_m_wdata   = r_wdata;
  assign tgt_m_wstrb   = r_wstrb;
  assign tgt_m_wvalid  = r_wvalid;
  assign tgt_m_bready  = r_bready;
  assign tgt_m_araddr  = r_araddr;
  assign tgt_m_arvalid = r_arvalid;
  assign tgt_m_rready  = r_rready;
  assign wr_err        = r_wr_err;

endmodule

// File: tb/tb_pci_target_ctrl.sv
// Directed bench for pci_target_ctrl: writes, bursts with aperture wrap, delayed reads, errors, reset.
module tb_pci_target_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ADDR = '0;
  logic        ADDR_VLD = 1'b0;
  logic [7:0]  BASE_HIT = '0;
  logic        S_WRDN = 1'b0;
  logic        S_DATA = 1'b0;
  logic        S_DATA_VLD = 1'b0;
  logic        S_SRC_EN = 1'b0;
  logic [3:0]  S_CBE = '0;
  logic [31:0] ADIO_OUT = '0;
  logic [31:0] ADIO_IN;
  logic        S_READY, S_TERM, S_ABORT;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready, wr_err;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pci_target_ctrl #(
    .BAR_NUM(0), .BAR_SIZE_LOG2(12), .AXI_BASE(32'h0), .DISCARD_CYCLES(16'd100)
  ) dut (
    .tgt_m_aclk(clk), .tgt_m_aresetn(rst_n),
    .ADDR(ADDR), .ADDR_VLD(ADDR_VLD), .BASE_HIT(BASE_HIT), .S_WRDN(S_WRDN),
    .S_DATA(S_DATA), .S_DATA_VLD(S_DATA_VLD), .S_SRC_EN(S_SRC_EN), .S_CBE(S_CBE),
    .ADIO_OUT(ADIO_OUT), .ADIO_IN(ADIO_IN), .S_READY(S_READY), .S_TERM(S_TERM), .S_ABORT(S_ABORT),
    .tgt_m_awaddr(awaddr), .tgt_m_awvalid(awvalid), .tgt_m_awready(awready),
    .tgt_m_wdata(wdata), .tgt_m_wstrb(wstrb), .tgt_m_wvalid(wvalid), .tgt_m_wready(wready),
    .tgt_m_bresp(bresp), .tgt_m_bvalid(bvalid), .tgt_m_bready(bready),
    .tgt_m_araddr(araddr), .tgt_m_arvalid(arvalid), .tgt_m_arready(arready),
    .tgt_m_rdata(rdata), .tgt_m_rresp(rresp), .tgt_m_rvalid(rvalid), .tgt_m_rready(rready),
    .wr_err(wr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ready,term,abort}
  function automatic logic [2:0] pci_flags();
    return {S_READY, S_TERM, S_ABORT};
  endfunction

  task automatic pci_hit(input logic [31:0] a, input logic wr);
    ADDR = a; ADDR_VLD = 1'b1; BASE_HIT = 8'h01; S_WRDN = wr; S_DATA = 1'b1;
    tick();
    ADDR_VLD = 1'b0; BASE_HIT = 8'h00;
  endtask

  task automatic wr_beat(input logic [31:0] d, input logic [3:0] cbe, input logic [31:0] exp_a,
                         input logic [3:0] exp_strb, input logic [1:0] resp);
    ADIO_OUT = d; S_CBE = cbe; S_DATA_VLD = 1'b1;
    tick();
    S_DATA_VLD = 1'b0;
    check_eq("wr_valids", {awvalid, wvalid, S_READY}, 3'b110);
    check_eq("wr_awaddr", awaddr, exp_a);
    check_eq("wr_wdata", wdata, d);
    check_eq("wr_wstrb", wstrb, exp_strb);
    awready = 1'b1; wready = 1'b1;
    tick();
    awready = 1'b0; wready = 1'b0;
    check_eq("wr_bready", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1; bresp = resp;
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    check_eq("wr_after_b", {bready, S_READY}, 2'b01);
  endtask

  task automatic axi_read(input logic [31:0] d, input logic [1:0] resp);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("rd_rready", {arvalid, rready}, 2'b01);
    rvalid = 1'b1; rdata = d; rresp = resp;
    tick();
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    check_eq("rd_latched", {arvalid, rready}, 2'b00);
  endtask

  initial begin
    repeat (3) tick();
    check_eq("rst_flags", {pci_flags(), awvalid, wvalid, bready, arvalid, rready, wr_err}, 9'h000);
    check_eq("rst_adio", ADIO_IN, 32'h0);
    rst_n = 1'b1;
    tick();

    // single write with independent AW/W ready
    pci_hit(32'h0000_0124, 1'b1);
    check_eq("w1_hit", pci_flags(), 3'b100);
    ADIO_OUT = 32'hDEAD_BEEF; S_CBE = 4'b0000; S_DATA_VLD = 1'b1;
    tick();
    S_DATA_VLD = 1'b0;
    check_eq("w1_valids", {awvalid, wvalid, S_READY}, 3'b110);
    check_eq("w1_awaddr", awaddr, 32'h0000_0124);
    check_eq("w1_wdata", wdata, 32'hDEAD_BEEF);
    check_eq("w1_wstrb", wstrb, 4'hF);
    awready = 1'b1;
    tick();
    awready = 1'b0;
    check_eq("w1_aw_only", {awvalid, wvalid, bready}, 3'b010);
    wready = 1'b1;
    tick();
    wready = 1'b0;
    check_eq("w1_w_done", {awvalid, wvalid, bready}, 3'b001);
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    check_eq("w1_ready_back", {S_READY, bready, wr_err}, 3'b100);
    S_DATA = 1'b0;
    tick();
    check_eq("w1_idle", pci_flags(), 3'b000);

    // burst wrapping at the 4 KiB aperture
    pci_hit(32'h0000_0FFC, 1'b1);
    wr_beat(32'h1111_1111, 4'b0000, 32'h0000_0FFC, 4'hF, 2'b00);
    wr_beat(32'h2222_2222, 4'b1010, 32'h0000_0000, 4'b0101, 2'b00);
    wr_beat(32'h3333_3333, 4'b1110, 32'h0000_0004, 4'b0001, 2'b00);
    S_DATA = 1'b0;
    tick();
    check_eq("burst_end", {pci_flags(), wr_err}, 4'b0000);

    // delayed read: retry, fetch, return
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("r1_retry", pci_flags(), 3'b010);
    check_eq("r1_ar", {arvalid, araddr}, {1'b1, 32'h0000_0040});
    S_DATA = 1'b0;
    tick();
    check_eq("r1_retry_end", pci_flags(), 3'b000);
    axi_read(32'h1234_5678, 2'b00);
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("r1_return", pci_flags(), 3'b110);
    check_eq("r1_data", ADIO_IN, 32'h1234_5678);
    S_DATA_VLD = 1'b1;
    tick();
    S_DATA_VLD = 1'b0; S_DATA = 1'b0;
    check_eq("r1_done", {pci_flags(), ADIO_IN}, 35'h0);

    // pending 0x40 survives other hits
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("r2_new_ar", {arvalid, araddr}, {1'b1, 32'h0000_0040});
    S_DATA = 1'b0;
    tick();
    pci_hit(32'h0000_0200, 1'b1);
    check_eq("r2_wr_retry", {pci_flags(), awvalid}, 4'b0100);
    S_DATA = 1'b0;
    tick();
    axi_read(32'hA5A5_0040, 2'b00);
    pci_hit(32'h0000_0080, 1'b0);
    check_eq("r2_other_retry", {pci_flags(), arvalid}, 4'b0100);
    check_eq("r2_other_adio", ADIO_IN, 32'h0);
    S_DATA = 1'b0;
    tick();
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("r2_return", pci_flags(), 3'b110);
    check_eq("r2_data", ADIO_IN, 32'hA5A5_0040);
    S_DATA_VLD = 1'b1;
    tick();
    S_DATA_VLD = 1'b0; S_DATA = 1'b0;
    tick();

    // read error becomes target abort
    pci_hit(32'h0000_0040, 1'b0);
    S_DATA = 1'b0;
    tick();
    axi_read(32'hFFFF_FFFF, 2'b10);
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("abort_set", {pci_flags(), ADIO_IN}, {3'b001, 32'h0});
    tick();
    check_eq("abort_hold", pci_flags(), 3'b001);
    S_DATA = 1'b0;
    tick();
    check_eq("abort_clear", pci_flags(), 3'b000);

    // write error is sticky
    pci_hit(32'h0000_0010, 1'b1);
    wr_beat(32'hCAFE_F00D, 4'b0000, 32'h0000_0010, 4'hF, 2'b11);
    check_eq("wr_err_set", wr_err, 1'b1);
    S_DATA = 1'b0;
    repeat (5) tick();
    check_eq("wr_err_sticky", wr_err, 1'b1);

    pci_hit(32'h0000_0040, 1'b0);
    S_DATA = 1'b0;
    tick();
    axi_read(32'h0BAD_F00D, 2'b00);
`ifdef PCI_TGT_DISCARD_EN
    repeat (105) tick();
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("disc_reissue", {arvalid, araddr}, {1'b1, 32'h0000_0040});
    check_eq("disc_retry", pci_flags(), 3'b010);
`else
    repeat (150) tick();
    pci_hit(32'h0000_0040, 1'b0);
    check_eq("hold_return", {pci_flags(), arvalid}, 4'b1100);
    check_eq("hold_data", ADIO_IN, 32'h0BAD_F00D);
`endif

    // asynchronous reset mid-transaction
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_flags", {pci_flags(), awvalid, wvalid, bready, arvalid, rready, wr_err}, 9'h000);
    check_eq("rst_mid_adio", ADIO_IN, 32'h0);
    S_DATA = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
